// File: rtl/dmem_axi_bridge_if.sv
// AXI4-Lite bus between the data-memory bridge (master) and the memory slave.
interface dmem_axi_bridge_if;
  logic        m_awvalid;
  logic        m_awready;
  logic [63:0] m_awaddr;
  logic        m_wvalid;
  logic        m_wready;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_bvalid;
  logic        m_bready;
  logic [1:0]  m_bresp;
  logic        m_arvalid;
  logic        m_arready;
  logic [63:0] m_araddr;
  logic        m_rvalid;
  logic        m_rready;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;

  modport master (
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
           m_arvalid, m_araddr, m_rready,
    input  m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid,
           m_rdata, m_rresp
  );

  modport slave (
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
           m_arvalid, m_araddr, m_rready,
    output m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid,
           m_rdata, m_rresp
  );
endinterface

// File: rtl/dmem_axi_bridge.sv
// Turns mem-stage level load/store requests into single AXI4-Lite transactions
// and returns a one-cycle mem_finish pulse; a timeout forces completion.
module dmem_axi_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic [63:0]       addr,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wmask,
  output logic [63:0]       rdata,
  output logic              mem_finish,
  output logic              bus_err,
  dmem_axi_bridge_if.master axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_DONE
  } state_t;

  localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);

  state_t           state_reg, state_next;
  logic             awvalid_reg, awvalid_next;
  logic             wvalid_reg, wvalid_next;
  logic             bready_reg, bready_next;
  logic             arvalid_reg, arvalid_next;
  logic             rready_reg, rready_next;
  logic             aw_done_reg, aw_done_next;
  logic             w_done_reg, w_done_next;
  logic [63:0]      addr_reg, addr_next;
  logic [63:0]      wdata_reg, wdata_next;
  logic [7:0]       wstrb_reg, wstrb_next;
  logic [63:0]      rdata_reg, rdata_next;
  logic             finish_reg, finish_next;
  logic             bus_err_reg, bus_err_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [CNT_W:0]   cnt_inc;
  logic             expired;
  logic             aw_hs;
  logic             w_hs;

  // The counter value after this cycle's increment decides expiry, so a
  // request state lasts at most TIMEOUT_CYCLES cycles.
  assign cnt_inc = {1'b0, cnt_reg} + 1'b1;
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIM);
  assign aw_hs   = awvalid_reg & axi.m_awready;
  assign w_hs    = wvalid_reg & axi.m_wready;

  always_comb begin
    state_next   = state_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    bready_next  = bready_reg;
    arvalid_next = arvalid_reg;
    rready_next  = rready_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    rdata_next   = rdata_reg;
    finish_next  = 1'b0;
    bus_err_next = 1'b0;
    cnt_next     = cnt_inc[CNT_W-1:0];

    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (we) begin
          state_next   = S_WR_REQ;
          addr_next    = addr & 64'hFFFF_FFFF_FFFF_FFF8;
          wdata_next   = wdata;
          wstrb_next   = wmask;
          awvalid_next = 1'b1;
          wvalid_next  = 1'b1;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end else if (re) begin
          state_next   = S_RD_REQ;
          addr_next    = addr & 64'hFFFF_FFFF_FFFF_FFF8;
          arvalid_next = 1'b1;
        end
      end

      S_WR_REQ: begin
        aw_done_next = aw_done_reg | aw_hs;
        w_done_next  = w_done_reg | w_hs;
        awvalid_next = awvalid_reg & ~aw_hs;
        wvalid_next  = wvalid_reg & ~w_hs;
        if (aw_done_next && w_done_next) begin
          state_next  = S_WR_RESP;
          bready_next = 1'b1;
          cnt_next    = '0;
        end else if (expired) begin
          state_next   = S_DONE;
          awvalid_next = 1'b0;
          wvalid_next  = 1'b0;
          rdata_next   = '0;
          finish_next  = 1'b1;
          bus_err_next = 1'b1;
          cnt_next     = '0;
        end
      end

      S_WR_RESP: begin
        if (axi.m_bvalid) begin
          state_next   = S_DONE;
          bready_next  = 1'b0;
          rdata_next   = '0;
          finish_next  = 1'b1;
          bus_err_next = (axi.m_bresp != 2'b00);
          cnt_next     = '0;
        end else if (expired) begin
          state_next   = S_DONE;
          bready_next  = 1'b0;
          rdata_next   = '0;
          finish_next  = 1'b1;
          bus_err_next = 1'b1;
          cnt_next     = '0;
        end
      end

      S_RD_REQ: begin
        if (axi.m_arready) begin
          state_next   = S_RD_RESP;
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          cnt_next     = '0;
        end else if (expired) begin
          state_next   = S_DONE;
          arvalid_next = 1'b0;
          rdata_next   = '0;
          finish_next  = 1'b1;
          bus_err_next = 1'b1;
          cnt_next     = '0;
        end
      end

      S_RD_RESP: begin
        if (axi.m_rvalid) begin
          state_next   = S_DONE;
          rready_next  = 1'b0;
          rdata_next   = axi.m_rdata;
          finish_next  = 1'b1;
          bus_err_next = (axi.m_rresp != 2'b00);
          cnt_next     = '0;
        end else if (expired) begin
          state_next   = S_DONE;
          rready_next  = 1'b0;
          rdata_next   = '0;
          finish_next  = 1'b1;
          bus_err_next = 1'b1;
          cnt_next     = '0;
        end
      end

      // Requests are not sampled here: the pipeline only advances on mem_finish.
      S_DONE: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      rdata_reg   <= '0;
      finish_reg  <= 1'b0;
      bus_err_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      bready_reg  <= bready_next;
      arvalid_reg <= arvalid_next;
      rready_reg  <= rready_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      rdata_reg   <= rdata_next;
      finish_reg  <= finish_next;
      bus_err_reg <= bus_err_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign rdata         = rdata_reg;
  assign mem_finish    = finish_reg;
  assign bus_err       = bus_err_reg;
  assign axi.m_awvalid = awvalid_reg;
  assign axi.m_awaddr  = addr_reg;
  assign axi.m_wvalid  = wvalid_reg;
  assign axi.m_wdata   = wdata_reg;
  assign axi.m_wstrb   = wstrb_reg;
  assign axi.m_bready  = bready_reg;
  assign axi.m_arvalid = arvalid_reg;
  assign axi.m_araddr  = addr_reg;
  assign axi.m_rready  = rready_reg;

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Directed bench for dmem_axi_bridge: reads, split writes, error responses,
// timeout, back-to-back loads and reset in the middle of a write.
module tb_dmem_axi_bridge;

  logic        clk;
  logic        rst;
  logic        re;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic [63:0] rdata;
  logic        mem_finish;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  dmem_axi_bridge_if axi_if ();

  dmem_axi_bridge #(
    .TIMEOUT_CYCLES(8),
    .CNT_W         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .re        (re),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .wmask     (wmask),
    .rdata     (rdata),
    .mem_finish(mem_finish),
    .bus_err   (bus_err),
    .axi       (axi_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic slave_quiet;
    axi_if.m_awready = 1'b0;
    axi_if.m_wready  = 1'b0;
    axi_if.m_bvalid  = 1'b0;
    axi_if.m_bresp   = 2'b00;
    axi_if.m_arready = 1'b0;
    axi_if.m_rvalid  = 1'b0;
    axi_if.m_rdata   = '0;
    axi_if.m_rresp   = 2'b00;
  endtask

  initial begin
    int n;
    int ar_cnt;
    int fin_cnt;
    int fin_prev;
    int fin_gap;

    rst = 1'b1; re = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; wmask = '0;
    slave_quiet();
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_finish",  {63'd0, mem_finish},       64'd0);
    chk("rst_arvalid", {63'd0, axi_if.m_arvalid}, 64'd0);
    chk("rst_awvalid", {63'd0, axi_if.m_awvalid}, 64'd0);
    chk("rst_rdata",   rdata,                     64'd0);
    $display("txn reset: outputs idle");

    // Read, always-ready slave
    re = 1'b1; addr = 64'h8000_0005;
    axi_if.m_arready = 1'b1; axi_if.m_rvalid = 1'b1;
    axi_if.m_rdata = 64'h1122_3344_5566_7788;
    tick();
    chk("rd_arvalid", {63'd0, axi_if.m_arvalid}, 64'd1);
    chk("rd_araddr",  axi_if.m_araddr,           64'h8000_0000);
    chk("rd_fin_n1",  {63'd0, mem_finish},       64'd0);
    tick();
    chk("rd_rready",  {63'd0, axi_if.m_rready},  64'd1);
    chk("rd_fin_n2",  {63'd0, mem_finish},       64'd0);
    tick();
    chk("rd_finish",  {63'd0, mem_finish},       64'd1);
    chk("rd_rdata",   rdata,                     64'h1122_3344_5566_7788);
    chk("rd_buserr",  {63'd0, bus_err},          64'd0);
    re = 1'b0; slave_quiet();
    tick();
    chk("rd_fin_low", {63'd0, mem_finish},       64'd0);
    chk("rd_hold",    rdata,                     64'h1122_3344_5566_7788);
    $display("txn read: addr=%h rdata=%h", 64'h8000_0005, rdata);

    // Write with AW accepted at +1 and W at +4
    we = 1'b1; addr = 64'h0000_010F; wmask = 8'h0C; wdata = 64'h0000_0000_ABCD_0000;
    tick();
    chk("wr_awvalid", {63'd0, axi_if.m_awvalid}, 64'd1);
    chk("wr_wvalid1", {63'd0, axi_if.m_wvalid},  64'd1);
    chk("wr_awaddr",  axi_if.m_awaddr,           64'h0000_0108);
    chk("wr_wstrb",   {56'd0, axi_if.m_wstrb},   64'h0C);
    chk("wr_wdata",   axi_if.m_wdata,            64'h0000_0000_ABCD_0000);
    axi_if.m_awready = 1'b1;
    tick();
    axi_if.m_awready = 1'b0;
    chk("wr_aw_drop", {63'd0, axi_if.m_awvalid}, 64'd0);
    chk("wr_wvalid2", {63'd0, axi_if.m_wvalid},  64'd1);
    chk("wr_bready0", {63'd0, axi_if.m_bready},  64'd0);
    tick();
    chk("wr_wvalid3", {63'd0, axi_if.m_wvalid},  64'd1);
    tick();
    chk("wr_wvalid4", {63'd0, axi_if.m_wvalid},  64'd1);
    chk("wr_bready4", {63'd0, axi_if.m_bready},  64'd0);
    axi_if.m_wready = 1'b1;
    tick();
    axi_if.m_wready = 1'b0;
    chk("wr_w_drop",  {63'd0, axi_if.m_wvalid},  64'd0);
    chk("wr_bready",  {63'd0, axi_if.m_bready},  64'd1);
    chk("wr_fin_n",   {63'd0, mem_finish},       64'd0);
    axi_if.m_bvalid = 1'b1;
    tick();
    chk("wr_finish",  {63'd0, mem_finish},       64'd1);
    chk("wr_buserr",  {63'd0, bus_err},          64'd0);
    chk("wr_rdata0",  rdata,                     64'd0);
    we = 1'b0; slave_quiet();
    tick();
    chk("wr_fin_low", {63'd0, mem_finish},       64'd0);
    $display("txn write split: addr=%h wstrb=0c", 64'h0000_010F);

    // Read with SLVERR
    re = 1'b1; addr = 64'h0000_0040;
    axi_if.m_arready = 1'b1; axi_if.m_rvalid = 1'b1;
    axi_if.m_rdata = 64'h0000_0000_0000_DEAD; axi_if.m_rresp = 2'b10;
    tick(); tick(); tick();
    chk("rderr_fin",  {63'd0, mem_finish},       64'd1);
    chk("rderr_err",  {63'd0, bus_err},          64'd1);
    re = 1'b0; slave_quiet();
    tick();
    chk("rderr_clr",  {63'd0, bus_err},          64'd0);
    $display("txn read rresp=2: bus_err observed");

    // Write with DECERR while re is also high: the write must win
    we = 1'b1; re = 1'b1; addr = 64'h0000_0208; wmask = 8'hFF; wdata = 64'h55;
    axi_if.m_awready = 1'b1; axi_if.m_wready = 1'b1;
    axi_if.m_bvalid = 1'b1; axi_if.m_bresp = 2'b11;
    tick();
    chk("wrerr_aw",   {63'd0, axi_if.m_awvalid}, 64'd1);
    chk("wrerr_noar", {63'd0, axi_if.m_arvalid}, 64'd0);
    tick(); tick();
    chk("wrerr_fin",  {63'd0, mem_finish},       64'd1);
    chk("wrerr_err",  {63'd0, bus_err},          64'd1);
    chk("wrerr_rd0",  rdata,                     64'd0);
    we = 1'b0; re = 1'b0; slave_quiet();
    tick();
    $display("txn write bresp=3 (re also high): bus_err observed");

    // Timeout: arready never asserted
    re = 1'b1; addr = 64'h0000_2000;
    axi_if.m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk("to_arvalid", {63'd0, axi_if.m_arvalid}, 64'd1);
    n = 1;
    while (!mem_finish && n < 20) begin
      tick();
      n++;
    end
    chk("to_window",  {63'd0, (n >= 9 && n <= 10)}, 64'd1);
    chk("to_fin",     {63'd0, mem_finish},       64'd1);
    chk("to_err",     {63'd0, bus_err},          64'd1);
    chk("to_ardrop",  {63'd0, axi_if.m_arvalid}, 64'd0);
    chk("to_rdata",   rdata,                     64'd0);
    re = 1'b0; slave_quiet();
    tick();
    $display("txn timeout: mem_finish after %0d cycles", n);

    // Back-to-back loads with re held across mem_finish
    re = 1'b1; addr = 64'h0000_0300;
    axi_if.m_arready = 1'b1; axi_if.m_rvalid = 1'b1;
    axi_if.m_rdata = 64'hCAFE_F00D_1234_5678;
    ar_cnt = 0; fin_cnt = 0; fin_prev = 0; fin_gap = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (axi_if.m_arvalid && axi_if.m_arready) ar_cnt++;
      if (mem_finish) begin
        fin_cnt++;
        if (fin_prev != 0) fin_gap = i - fin_prev;
        fin_prev = i;
      end
      if (i == 7) re = 1'b0;
    end
    chk("b2b_ar",     64'(ar_cnt),               64'd2);
    chk("b2b_fin",    64'(fin_cnt),              64'd2);
    chk("b2b_gap",    64'(fin_gap),              64'd4);
    chk("b2b_rdata",  rdata,                     64'hCAFE_F00D_1234_5678);
    slave_quiet();
    tick();
    $display("txn back-to-back: ar=%0d finish=%0d gap=%0d", ar_cnt, fin_cnt, fin_gap);

    // Reset while waiting for the write response
    we = 1'b1; addr = 64'h0000_0400; wmask = 8'hF0; wdata = 64'h1;
    axi_if.m_awready = 1'b1; axi_if.m_wready = 1'b1;
    tick(); tick();
    chk("rstw_bready", {63'd0, axi_if.m_bready}, 64'd1);
    rst = 1'b1;
    tick();
    chk("rstw_bready0", {63'd0, axi_if.m_bready},  64'd0);
    chk("rstw_fin",     {63'd0, mem_finish},       64'd0);
    chk("rstw_aw",      {63'd0, axi_if.m_awvalid}, 64'd0);
    chk("rstw_rdata",   rdata,                     64'd0);
    rst = 1'b0; we = 1'b0; slave_quiet();
    tick();
    chk("rstw_fin2",    {63'd0, mem_finish},       64'd0);
    re = 1'b1; addr = 64'h0000_0018;
    axi_if.m_arready = 1'b1; axi_if.m_rvalid = 1'b1;
    axi_if.m_rdata = 64'h0BAD_BEEF_0000_0001;
    tick(); tick(); tick();
    chk("rstw_rdfin",   {63'd0, mem_finish},       64'd1);
    chk("rstw_rddata",  rdata,                     64'h0BAD_BEEF_0000_0001);
    chk("rstw_rderr",   {63'd0, bus_err},          64'd0);
    re = 1'b0; slave_quiet();
    tick();
    $display("txn reset mid-write then read: rdata=%h", rdata);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
